// File: rtl/imem_loader.sv
// Serial instruction-memory loader: LE word count N, then N LE words, written to imem before releasing the core.
// Optional trailing checksum enabled by macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  out_ready,
  output logic                  out_imem_we,
  output logic [ADDR_WIDTH-1:0] out_imem_addr,
  output logic [31:0]           out_imem_wdata,
  output logic                  out_core_reset,
  output logic                  out_done,
  output logic                  out_error
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK  = 3'd2,
`endif
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                state_r;
  state_t                state_nxt_s;
  logic [1:0]            byte_cnt_r;
  logic [23:0]           asm_r;
  logic [ADDR_WIDTH:0]   word_cnt_r;
  logic [ADDR_WIDTH:0]   last_idx_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  ready_r;
  logic                  core_reset_r;
  logic                  done_r;
  logic                  error_r;
  logic                  accept_s;
  logic                  last_byte_s;
  logic [31:0]           full_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_r;
`endif

  assign accept_s    = in_valid & ready_r;
  assign last_byte_s = accept_s & (byte_cnt_r == 2'd3);
  // Completed word: three buffered bytes below the byte arriving now.
  assign full_s      = {in_byte, asm_r};

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_LEN: begin
        if (last_byte_s) begin
          if (full_s == 32'd0) begin
            state_nxt_s = S_TAIL;
          end else if ({1'b0, full_s} > DEPTH) begin
            state_nxt_s = S_ERR;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_DATA: begin
        if (last_byte_s && (word_cnt_r == last_idx_r)) begin
          state_nxt_s = S_TAIL;
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (last_byte_s) begin
          state_nxt_s = (full_s == sum_r) ? S_DONE : S_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
`endif
      S_DONE:  state_nxt_s = S_DONE;
      S_ERR:   state_nxt_s = S_ERR;
      default: state_nxt_s = S_ERR;
    endcase
  end

  // State register and status outputs; core reset drops one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_LEN;
      ready_r      <= 1'b0;
      core_reset_r <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ready_r      <= (state_nxt_s == S_LEN) || (state_nxt_s == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      || (state_nxt_s == S_CHK)
`endif
                      ;
      core_reset_r <= (state_r != S_DONE);
      done_r       <= (state_r == S_DONE);
      error_r      <= (state_r == S_ERR);
    end
  end

  // Byte assembly, word counting and the registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      word_cnt_r <= '0;
      last_idx_r <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
    end else begin
      we_r <= 1'b0;
      if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        asm_r      <= {in_byte, asm_r[23:8]};
        if (byte_cnt_r == 2'd3) begin
          case (state_r)
            S_LEN: last_idx_r <= full_s[ADDR_WIDTH:0] - (ADDR_WIDTH+1)'(1);
            S_DATA: begin
              we_r       <= 1'b1;
              addr_r     <= word_cnt_r[ADDR_WIDTH-1:0];
              wdata_r    <= full_s;
              word_cnt_r <= word_cnt_r + (ADDR_WIDTH+1)'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running mod-2^32 sum of every written word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_r <= 32'd0;
    end else if (last_byte_s && (state_r == S_DATA)) begin
      sum_r <= sum_r + full_s;
    end
  end
`endif

  assign out_ready      = ready_r;
  assign out_imem_we    = we_r;
  assign out_imem_addr  = addr_r;
  assign out_imem_wdata = wdata_r;
  assign out_core_reset = core_reset_r;
  assign out_done       = done_r;
  assign out_error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed load streams plus randomized streams against a stream-parsing model.
module tb_imem_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'd0;
  logic          out_ready, out_imem_we, out_core_reset, out_done, out_error;
  logic [AW-1:0] out_imem_addr;
  logic [31:0]   out_imem_wdata;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .out_ready(out_ready), .out_imem_we(out_imem_we), .out_imem_addr(out_imem_addr),
    .out_imem_wdata(out_imem_wdata), .out_core_reset(out_core_reset),
    .out_done(out_done), .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          cr_fall_cycle = -1;
  bit          prev_cr = 1'b1;
  logic [31:0] last_wdata = 32'd0;
  logic [AW-1:0] last_addr = '0;
  wr_t         exp_q[$];
  int          we_cycles[$];
  logic [7:0]  stream[$];
  logic [31:0] wq[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of the write port and status against the expected write queue.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (!reset) begin
      check("rst_ready", 64'(out_ready), 64'd0);
      check("rst_we", 64'(out_imem_we), 64'd0);
      check("rst_addr", 64'(out_imem_addr), 64'd0);
      check("rst_wdata", 64'(out_imem_wdata), 64'd0);
      check("rst_core_reset", 64'(out_core_reset), 64'd1);
      check("rst_done", 64'(out_done), 64'd0);
      check("rst_error", 64'(out_error), 64'd0);
    end else begin
      if (out_imem_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", 64'(out_imem_addr), 64'(e.a));
          check("we_data", 64'(out_imem_wdata), 64'(e.d));
          check("we_core_reset", 64'(out_core_reset), 64'd1);
          we_cycles.push_back(cyc);
          last_wdata = out_imem_wdata;
          last_addr  = out_imem_addr;
        end
      end
      if (prev_cr && !out_core_reset) cr_fall_cycle = cyc;
      if (out_done || out_error) begin
        check("done_error_excl", 64'(out_done & out_error), 64'd0);
        check("core_reset_vs_error", 64'(out_core_reset), 64'(out_error));
      end
    end
    prev_cr = out_core_reset;
  end

  function automatic void push_word(input logic [31:0] w);
    stream.push_back(w[7:0]);
    stream.push_back(w[15:8]);
    stream.push_back(w[23:16]);
    stream.push_back(w[31:24]);
  endfunction

  function automatic logic [31:0] word_at(input int idx);
    return {stream[idx+3], stream[idx+2], stream[idx+1], stream[idx]};
  endfunction

  task automatic build(input logic [31:0] n, input bit bad_chk);
    logic [31:0] s;
    s = 32'd0;
    stream.delete();
    push_word(n);
    if (n <= 32'(DEPTH)) begin
      for (int k = 0; 32'(k) < n; k++) begin
        push_word(wq[k]);
        s = s + wq[k];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(bad_chk ? s + 32'd1 : s);
`else
      if (bad_chk) s = 32'd0;
`endif
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.delete();
    we_cycles.delete();
    cr_fall_cycle = -1;
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    repeat (gap) @(negedge clk);
    budget = 50;
    while (!out_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!out_ready) check("ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_check(input bit exp_err);
    in_valid = 1'b1;
    repeat (4) begin
      in_byte = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("final_done", 64'(out_done), 64'(!exp_err));
    check("final_error", 64'(out_error), 64'(exp_err));
    check("final_core_reset", 64'(out_core_reset), 64'(exp_err));
    check("final_ready", 64'(out_ready), 64'd0);
    check("missing_writes", 64'(exp_q.size()), 64'd0);
    if (!exp_err && we_cycles.size() > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("core_reset_after_we", 64'(cr_fall_cycle > we_cycles[$]), 64'd1);
`else
      check("core_reset_fall_cycle", 64'(cr_fall_cycle), 64'(we_cycles[$] + 1));
`endif
    end
  endtask

  // Sends the first stop_after bytes (all when negative) and checks the outcome the stream implies.
  task automatic run(input int gapmax, input bit fixed_gap, input int stop_after);
    int          nb;
    logic [31:0] n;
    bit          err;
    nb = (stop_after < 0) ? stream.size() : stop_after;
    n  = word_at(0);
    if (nb >= 4 && n <= 32'(DEPTH)) begin
      for (int k = 0; 32'(k) < n && 4*k + 7 < nb; k++) begin
        exp_q.push_back('{AW'(k), word_at(4*k + 4)});
      end
    end
    for (int i = 0; i < nb; i++) begin
      send_byte(stream[i], fixed_gap ? gapmax : int'($urandom_range(gapmax, 0)));
    end
    if (stop_after >= 0) begin
      check("partial_writes", 64'(exp_q.size()), 64'd0);
    end else begin
      err = (n > 32'(DEPTH));
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!err) begin
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; 32'(k) < n; k++) s = s + word_at(4*k + 4);
        err = (word_at(4 + 4*int'(n)) != s);
      end
`endif
      finish_check(err);
    end
  endtask

  initial begin
    logic [31:0] n;
    int          stop;
    do_reset(3);
    @(negedge clk);
    check("ready_after_reset", 64'(out_ready), 64'd1);
    check("core_reset_in_len", 64'(out_core_reset), 64'd1);

    // Two words back-to-back
    wq = '{32'h03200093, 32'h02300113};
    build(32'd2, 1'b0);
    check("stream_byte4", 64'(stream[4]), 64'h93);
    run(0, 1'b1, -1);
    check("we_spacing", 64'((we_cycles.size() == 2) ? we_cycles[1] - we_cycles[0] : -1), 64'd4);
    check("last_wdata_b2b", 64'(last_wdata), 64'h02300113);
    check("last_addr_b2b", 64'(last_addr), 64'd1);

    // Same stream with three idle cycles before every byte
    do_reset(2);
    run(3, 1'b1, -1);
    check("we_spacing_gap", 64'((we_cycles.size() == 2) ? we_cycles[1] - we_cycles[0] : -1), 64'd16);
    check("last_wdata_gap", 64'(last_wdata), 64'h02300113);

    // Empty program
    do_reset(2);
    wq.delete();
    build(32'd0, 1'b0);
    run(1, 1'b0, -1);
    check("n0_no_writes", 64'(we_cycles.size()), 64'd0);

    // Oversized count
    do_reset(2);
    build(32'd5, 1'b0);
    check("n5_stream_len", 64'(stream.size()), 64'd4);
    run(0, 1'b1, -1);
    check("n5_no_writes", 64'(we_cycles.size()), 64'd0);

    // Full depth, no wrap
    do_reset(2);
    wq = '{$urandom, $urandom, $urandom, $urandom};
    build(32'(DEPTH), 1'b0);
    run(2, 1'b0, -1);
    check("full_depth_last_addr", 64'(last_addr), 64'd3);
    check("full_depth_writes", 64'(we_cycles.size()), 64'd4);

    // Abort after six data bytes, then reload one word
    do_reset(2);
    wq = '{$urandom, $urandom};
    build(32'd2, 1'b0);
    run(1, 1'b0, 10);
    do_reset(1);
    wq = '{32'h002080b3};
    build(32'd1, 1'b0);
    run(0, 1'b1, -1);
    check("reload_wdata", 64'(last_wdata), 64'h002080b3);
    check("reload_addr", 64'(last_addr), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset(2);
    wq = '{32'h00000001, 32'h00000002};
    build(32'd2, 1'b0);
    check("chk_byte", 64'(stream[12]), 64'h03);
    run(0, 1'b1, -1);
    do_reset(2);
    build(32'd2, 1'b1);
    check("chk_bad_byte", 64'(stream[12]), 64'h04);
    run(0, 1'b1, -1);
`endif

    repeat (40) begin
      do_reset(1 + int'($urandom_range(2, 0)));
      n = 32'($urandom_range(DEPTH + 1, 0));
      if ($urandom_range(7, 0) == 0) n = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      wq.delete();
      repeat (DEPTH) wq.push_back($urandom);
      build(n, 1'($urandom_range(1, 0)));
      stop = ($urandom_range(4, 0) == 0) ? int'($urandom_range(stream.size() - 1, 1)) : -1;
      run(int'($urandom_range(3, 0)), 1'b0, stop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL global_timeout: got no completion, expected finish before 1ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
